// File: rtl/drygascon_pkg.sv
// Shared definitions for the DryGASCON input front-end: segment type codes,
// loader FSM encodings, the padding byte and an elaboration-time log2 helper.
package drygascon_pkg;

    typedef logic [3:0] hdr_t;

    localparam hdr_t HDR_AD       = 4'b0001;
    localparam hdr_t HDR_NPUB     = 4'b1101;
    localparam hdr_t HDR_PT       = 4'b0100;
    localparam hdr_t HDR_CT       = 4'b0101;
    localparam hdr_t HDR_HASH_MSG = 4'b0111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYCHK = 3'd1;
    localparam logic [2:0] S_LDKEY  = 3'd2;
    localparam logic [2:0] S_LD     = 3'd3;
    localparam logic [2:0] S_PAD    = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam logic [7:0] PAD_BYTE = 8'h01;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/drygascon_bdi_loader_if.sv
// Key / bdi input streams and the block output port of the DryGASCON loader.
// slave = loader side, master = producer of key/bdi and consumer of blocks.
interface drygascon_bdi_loader_if #(
    parameter int CCW        = 32,
    parameter int CCSW       = 32,
    parameter int SIZE_KEY   = 256,
    parameter int SIZE_BLOCK = 256
);
    localparam int NB_W = drygascon_pkg::clog2(SIZE_BLOCK / 8) + 1;

    logic [CCSW-1:0]       key;
    logic                  key_valid;
    logic                  key_ready;
    logic                  key_update;
    logic [CCW-1:0]        bdi;
    logic                  bdi_valid;
    logic                  bdi_ready;
    logic [CCW/8-1:0]      bdi_valid_bytes;
    logic [3:0]            bdi_type;
    logic                  bdi_eot;
    logic                  bdi_eoi;
    logic [SIZE_KEY-1:0]   key_out;
    logic                  key_loaded;
    logic [SIZE_BLOCK-1:0] blk_data;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [3:0]            blk_type;
    logic                  blk_eot;
    logic                  blk_eoi;
    logic [NB_W-1:0]       blk_nbytes;
    logic                  blk_padded;

    modport master (
        output key, key_valid, key_update, bdi, bdi_valid, bdi_valid_bytes,
               bdi_type, bdi_eot, bdi_eoi, blk_ready,
        input  key_ready, bdi_ready, key_out, key_loaded, blk_data, blk_valid,
               blk_type, blk_eot, blk_eoi, blk_nbytes, blk_padded
    );

    modport slave (
        input  key, key_valid, key_update, bdi, bdi_valid, bdi_valid_bytes,
               bdi_type, bdi_eot, bdi_eoi, blk_ready,
        output key_ready, bdi_ready, key_out, key_loaded, blk_data, blk_valid,
               blk_type, blk_eot, blk_eoi, blk_nbytes, blk_padded
    );

endinterface

// File: rtl/drygascon_word_padder.sv
// Combinational word padder: keeps the valid (left-contiguous) bytes, puts the
// pad byte in the first invalid position when pad_first is set, zeroes the rest.
module drygascon_word_padder
    import drygascon_pkg::*;
#(
    parameter int CCW = 32
) (
    input  logic [CCW-1:0]   word,
    input  logic [CCW/8-1:0] valid_bytes,
    input  logic             pad_first,
    output logic [CCW-1:0]   padded
);
    localparam int NBYTES = CCW / 8;

    // Byte walk from the most significant (first) byte downwards
    always_comb begin
        logic seen;
        padded = '0;
        seen   = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            if (valid_bytes[NBYTES-1-i]) begin
                padded[CCW-1-8*i -: 8] = word[CCW-1-8*i -: 8];
            end else if (!seen) begin
                padded[CCW-1-8*i -: 8] = pad_first ? PAD_BYTE : 8'h00;
                seen = 1'b1;
            end else begin
                padded[CCW-1-8*i -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/drygascon_bdi_loader.sv
// DryGASCON input front-end: assembles key and bdi words into full-width key and
// block registers, pads short blocks and presents tagged blocks over valid/ready.
module drygascon_bdi_loader
    import drygascon_pkg::*;
#(
    parameter int CCW        = 32,
    parameter int CCSW       = 32,
    parameter int SIZE_KEY   = 256,
    parameter int SIZE_BLOCK = 256,
    parameter int SIZE_NPUB  = 128
) (
    input logic clk,
    input logic rst_n,
    drygascon_bdi_loader_if.slave bus
);
    localparam int NK      = SIZE_KEY / CCSW;
    localparam int NW_BLK  = SIZE_BLOCK / CCW;
    localparam int NW_NPUB = SIZE_NPUB / CCW;
    localparam int NBYTES  = CCW / 8;
    localparam int CNT_W   = clog2(NW_BLK + 1);
    localparam int KCNT_W  = clog2(NK + 1);
    localparam int NB_W    = clog2(SIZE_BLOCK / 8) + 1;

    logic [2:0]            state_r, state_nxt_s;
    logic [SIZE_KEY-1:0]   key_r;
    logic [KCNT_W-1:0]     key_cnt_r;
    logic                  key_loaded_r, key_ready_r, bdi_ready_r, blk_valid_r;
    logic [SIZE_BLOCK-1:0] blk_r, blk_nxt_s;
    logic [CNT_W-1:0]      word_cnt_r, nw_r, nw_s;
    logic [NB_W-1:0]       nbytes_r, nbytes_sum_s, nbytes_nxt_s, cap_s;
    logic [3:0]            type_r;
    logic                  eot_r, eoi_r, padded_r, pad_first_r;
    logic                  key_hs_s, bdi_hs_s, key_last_s, last_word_s, need_pad_s;
    logic [CCW-1:0]        pad_in_s, pad_word_s;
    logic [NBYTES-1:0]     pad_vb_s;
    logic                  pad_first_s;

    function automatic logic [NB_W-1:0] count_bytes(input logic [NBYTES-1:0] vb);
        logic [NB_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NBYTES; i++) begin
            cnt = cnt + NB_W'(vb[i]);
        end
        return cnt;
    endfunction

    // Handshakes, block geometry of the current word and saturating byte count
    always_comb begin
        key_hs_s     = bus.key_valid & key_ready_r;
        bdi_hs_s     = bus.bdi_valid & bdi_ready_r;
        key_last_s   = (key_cnt_r == KCNT_W'(NK - 1));
        nw_s         = (bus.bdi_type == HDR_NPUB) ? CNT_W'(NW_NPUB) : CNT_W'(NW_BLK);
        cap_s        = (bus.bdi_type == HDR_NPUB) ? NB_W'(SIZE_NPUB / 8) : NB_W'(SIZE_BLOCK / 8);
        nbytes_sum_s = nbytes_r + count_bytes(bus.bdi_valid_bytes);
        nbytes_nxt_s = (nbytes_sum_s > cap_s) ? cap_s : nbytes_sum_s;
        last_word_s  = (word_cnt_r == nw_s - CNT_W'(1)) || bus.bdi_eot;
        need_pad_s   = (word_cnt_r != nw_s - CNT_W'(1));
    end

    // One padder serves both the final data word and the trailing pad words
    always_comb begin
        if (state_r == S_PAD) begin
            pad_in_s    = '0;
            pad_vb_s    = '0;
            pad_first_s = pad_first_r;
        end else begin
            pad_in_s    = bus.bdi;
            pad_vb_s    = bus.bdi_valid_bytes;
            pad_first_s = 1'b1;
        end
    end

    drygascon_word_padder #(.CCW(CCW)) u_padder (
        .word        (pad_in_s),
        .valid_bytes (pad_vb_s),
        .pad_first   (pad_first_s),
        .padded      (pad_word_s)
    );

    // Drop the padded word into its left-aligned slot of the block
    always_comb begin
        blk_nxt_s = blk_r;
        for (int i = 0; i < NW_BLK; i++) begin
            blk_nxt_s[SIZE_BLOCK-1-i*CCW -: CCW] =
                (word_cnt_r == CNT_W'(i)) ? pad_word_s : blk_r[SIZE_BLOCK-1-i*CCW -: CCW];
        end
    end

    // Next-state logic of the loader FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.key_valid || bus.bdi_valid) state_nxt_s = S_KEYCHK;
                else                                state_nxt_s = S_IDLE;
            end
            S_KEYCHK: begin
                if (bus.key_update || !key_loaded_r) state_nxt_s = S_LDKEY;
                else                                 state_nxt_s = S_LD;
            end
            S_LDKEY: begin
                if (key_hs_s && key_last_s) state_nxt_s = S_LD;
                else                        state_nxt_s = S_LDKEY;
            end
            S_LD: begin
                if (bdi_hs_s && last_word_s) state_nxt_s = need_pad_s ? S_PAD : S_HOLD;
                else                         state_nxt_s = S_LD;
            end
            S_PAD: begin
                if (word_cnt_r == nw_r - CNT_W'(1)) state_nxt_s = S_HOLD;
                else                                state_nxt_s = S_PAD;
            end
            S_HOLD: begin
                if (bus.blk_ready) state_nxt_s = eoi_r ? S_IDLE : S_LD;
                else               state_nxt_s = S_HOLD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, registered handshake outputs, key and block datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            key_r        <= '0;
            key_cnt_r    <= '0;
            key_loaded_r <= 1'b0;
            key_ready_r  <= 1'b0;
            bdi_ready_r  <= 1'b0;
            blk_valid_r  <= 1'b0;
            blk_r        <= '0;
            word_cnt_r   <= '0;
            nw_r         <= '0;
            nbytes_r     <= '0;
            type_r       <= 4'h0;
            eot_r        <= 1'b0;
            eoi_r        <= 1'b0;
            padded_r     <= 1'b0;
            pad_first_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            key_ready_r <= (state_nxt_s == S_LDKEY);
            bdi_ready_r <= (state_nxt_s == S_LD);
            blk_valid_r <= (state_nxt_s == S_HOLD);
            case (state_r)
                S_KEYCHK: begin
                    if (bus.key_update || !key_loaded_r) key_loaded_r <= 1'b0;
                    else                                 key_loaded_r <= key_loaded_r;
                end
                S_LDKEY: begin
                    if (key_hs_s) begin
                        key_r <= {key_r[SIZE_KEY-CCSW-1:0], bus.key};
                        if (key_last_s) begin
                            key_cnt_r    <= '0;
                            key_loaded_r <= 1'b1;
                        end else begin
                            key_cnt_r <= key_cnt_r + KCNT_W'(1);
                        end
                    end
                end
                S_LD: begin
                    if (bdi_hs_s) begin
                        blk_r    <= blk_nxt_s;
                        nbytes_r <= nbytes_nxt_s;
                        type_r   <= bus.bdi_type;
                        eot_r    <= bus.bdi_eot;
                        eoi_r    <= bus.bdi_eoi;
                        nw_r     <= nw_s;
                        if (last_word_s) begin
                            padded_r    <= (nbytes_nxt_s < cap_s);
                            // A full final word leaves the pad byte for the next word
                            pad_first_r <= &bus.bdi_valid_bytes;
                            word_cnt_r  <= need_pad_s ? word_cnt_r + CNT_W'(1) : '0;
                        end else begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end
                end
                S_PAD: begin
                    blk_r       <= blk_nxt_s;
                    pad_first_r <= 1'b0;
                    if (word_cnt_r == nw_r - CNT_W'(1)) word_cnt_r <= '0;
                    else                                word_cnt_r <= word_cnt_r + CNT_W'(1);
                end
                S_HOLD: begin
                    if (bus.blk_ready) begin
                        blk_r    <= '0;
                        nbytes_r <= '0;
                    end
                end
                default: begin
                    word_cnt_r <= word_cnt_r;
                end
            endcase
        end
    end

    assign bus.key_ready  = key_ready_r;
    assign bus.bdi_ready  = bdi_ready_r;
    assign bus.key_out    = key_r;
    assign bus.key_loaded = key_loaded_r;
    assign bus.blk_data   = blk_r;
    assign bus.blk_valid  = blk_valid_r;
    assign bus.blk_type   = type_r;
    assign bus.blk_eot    = eot_r;
    assign bus.blk_eoi    = eoi_r;
    assign bus.blk_nbytes = nbytes_r;
    assign bus.blk_padded = padded_r;

endmodule

// File: tb/tb_drygascon_bdi_loader.sv
// Self-checking bench for drygascon_bdi_loader: directed scenarios plus random
// inputs, expected blocks built from byte lists (data, 0x01, zeros).
module tb_drygascon_bdi_loader;
    import drygascon_pkg::*;

    localparam int CCW = 32, CCSW = 32, SIZE_KEY = 256, SIZE_BLOCK = 256, SIZE_NPUB = 128;

    typedef logic [7:0] byte_q[$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   key_rdy_cnt = 0;
    logic [255:0] exp_key;

    always #5 clk = ~clk;

    drygascon_bdi_loader_if #(.CCW(CCW), .CCSW(CCSW), .SIZE_KEY(SIZE_KEY),
                              .SIZE_BLOCK(SIZE_BLOCK)) bus ();

    drygascon_bdi_loader #(.CCW(CCW), .CCSW(CCSW), .SIZE_KEY(SIZE_KEY),
                           .SIZE_BLOCK(SIZE_BLOCK), .SIZE_NPUB(SIZE_NPUB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.key_ready === 1'b1) key_rdy_cnt <= key_rdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_key(input logic [255:0] k);
        int n;
        bus.key_update = 1'b1;
        for (int w = 0; w < 8; w++) begin
            bus.key       = k[255-32*w -: 32];
            bus.key_valid = 1'b1;
            n = 0;
            while (bus.key_ready !== 1'b1 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 200) check("key_ready_timeout", 256'd0, 256'd1);
            @(posedge clk); #1;
        end
        bus.key_valid  = 1'b0;
        bus.key_update = 1'b0;
        exp_key = k;
        check("key_out", bus.key_out, exp_key);
        check("key_loaded", bus.key_loaded, 256'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] vb, input logic [3:0] t,
                             input logic eot, input logic eoi);
        int n;
        bus.bdi = d; bus.bdi_valid_bytes = vb; bus.bdi_type = t;
        bus.bdi_eot = eot; bus.bdi_eoi = eoi; bus.bdi_valid = 1'b1;
        n = 0;
        while (bus.bdi_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("bdi_ready_timeout", 256'd0, 256'd1);
        check("key_ready_excl", bus.key_ready, 256'd0);
        @(posedge clk); #1;
        bus.bdi_valid = 1'b0;
    endtask

    task automatic recv_block(input logic [255:0] d, input logic [3:0] t, input logic eot,
                              input logic eoi, input int nb, input logic pad,
                              input int lat, input int stall);
        int n;
        n = 0;
        while (bus.blk_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("blk_latency", n, lat);
        check("blk_data", bus.blk_data, d);
        check("blk_type", bus.blk_type, t);
        check("blk_eot", bus.blk_eot, eot);
        check("blk_eoi", bus.blk_eoi, eoi);
        check("blk_nbytes", bus.blk_nbytes, nb);
        check("blk_padded", bus.blk_padded, pad);
        check("hold_bdi_ready", bus.bdi_ready, 256'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_bdi_ready", bus.bdi_ready, 256'd0);
            check("stall_blk_valid", bus.blk_valid, 256'd1);
            check("stall_blk_data", bus.blk_data, d);
        end
        bus.blk_ready = 1'b1;
        @(posedge clk); #1;
        bus.blk_ready = 1'b0;
        check("blk_valid_drop", bus.blk_valid, 256'd0);
    endtask

    // Reference: split the segment into blocks, append 0x01 then zeros to a short block
    task automatic run_segment(input logic [3:0] t, input byte_q data, input logic last_seg,
                               input int stall);
        int nwb, len, pos, chunk, nwords, nvalid;
        logic final_chunk;
        logic [255:0] exp_blk;
        logic [31:0] wd;
        logic [3:0] vb;
        nwb = (t == HDR_NPUB) ? 16 : 32;
        len = data.size();
        pos = 0;
        final_chunk = 1'b0;
        while (!final_chunk) begin
            chunk = (len - pos < nwb) ? len - pos : nwb;
            final_chunk = (pos + chunk == len);
            nwords = final_chunk ? (chunk + 3) / 4 : nwb / 4;
            if (nwords == 0) nwords = 1;
            for (int w = 0; w < nwords; w++) begin
                nvalid = chunk - 4 * w;
                if (nvalid > 4) nvalid = 4;
                wd = $urandom;
                vb = 4'b0000;
                for (int b = 0; b < nvalid; b++) begin
                    wd[31-8*b -: 8] = data[pos+4*w+b];
                    vb[3-b] = 1'b1;
                end
                send_word(wd, vb, t, final_chunk && (w == nwords - 1),
                          final_chunk && last_seg && (w == nwords - 1));
            end
            exp_blk = '0;
            for (int i = 0; i < chunk; i++) exp_blk[255-8*i -: 8] = data[pos+i];
            if (chunk < nwb) exp_blk[255-8*chunk -: 8] = 8'h01;
            recv_block(exp_blk, t, final_chunk, final_chunk && last_seg, chunk, chunk < nwb,
                       nwb / 4 - nwords, stall);
            pos += chunk;
        end
    endtask

    initial begin
        byte_q q;
        logic [255:0] k;
        int snap;
        rst_n = 1'b0;
        bus.key = '0; bus.key_valid = 1'b0; bus.key_update = 1'b0;
        bus.bdi = '0; bus.bdi_valid = 1'b0; bus.bdi_valid_bytes = '0;
        bus.bdi_type = 4'h0; bus.bdi_eot = 1'b0; bus.bdi_eoi = 1'b0; bus.blk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_valid", bus.blk_valid, 256'd0);
        check("rst_key_ready", bus.key_ready, 256'd0);
        check("rst_bdi_ready", bus.bdi_ready, 256'd0);
        check("rst_key_loaded", bus.key_loaded, 256'd0);
        check("rst_key_out", bus.key_out, 256'd0);
        check("rst_blk_data", bus.blk_data, 256'd0);
        check("rst_blk_nbytes", bus.blk_nbytes, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Key 00..1F then nonce 20..2F, input continues
        for (int i = 0; i < 32; i++) k[255-8*i -: 8] = 8'(i);
        send_key(k);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h20 + i));
        run_segment(HDR_NPUB, q, 1'b0, 0);

        // Full 32-byte PT ends the input
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(8'(8'h40 + i));
        run_segment(HDR_PT, q, 1'b1, 0);
        @(posedge clk); #1;
        check("idle_bdi_ready", bus.bdi_ready, 256'd0);
        check("idle_key_ready", bus.key_ready, 256'd0);

        // Second input without key update: 5-byte PT, then no key_ready activity
        snap = key_rdy_cnt;
        q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_segment(HDR_PT, q, 1'b1, 0);
        check("no_key_ready_pulse", key_rdy_cnt - snap, 256'd0);
        check("key_out_kept", bus.key_out, exp_key);

        // 8 bytes on a word boundary, then a back-pressured block, then an empty segment
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_segment(HDR_PT, q, 1'b1, 0);
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_segment(HDR_AD, q, 1'b0, 10);
        q = {};
        run_segment(HDR_PT, q, 1'b1, 0);
        check("key_out_kept2", bus.key_out, exp_key);

        // Random inputs with occasional rekeying
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
                send_key(k);
            end
            if ($urandom_range(0, 1) == 1) begin
                q = {};
                for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
                run_segment(HDR_NPUB, q, 1'b0, 0);
            end
            q = {};
            for (int i = 0; i < int'($urandom_range(0, 70)); i++) q.push_back(8'($urandom));
            run_segment(HDR_AD, q, 1'b0, int'($urandom_range(0, 2)));
            q = {};
            for (int i = 0; i < int'($urandom_range(0, 70)); i++) q.push_back(8'($urandom));
            run_segment(HDR_PT, q, 1'b1, 0);
            check("rand_key_out", bus.key_out, exp_key);
        end

        // Reset in the middle of a block load
        send_word(32'h01020304, 4'hF, HDR_PT, 1'b0, 1'b0);
        send_word(32'h05060708, 4'hF, HDR_PT, 1'b0, 1'b0);
        send_word(32'h090A0B0C, 4'hF, HDR_PT, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_blk_valid", bus.blk_valid, 256'd0);
        check("midrst_key_loaded", bus.key_loaded, 256'd0);
        check("midrst_bdi_ready", bus.bdi_ready, 256'd0);
        check("midrst_blk_data", bus.blk_data, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle_bdi_ready", bus.bdi_ready, 256'd0);
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_key(k);
        q = {8'h5A, 8'hA5, 8'h3C};
        run_segment(HDR_PT, q, 1'b1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
